uart_reg_bridge: RTL and testbench
==================================

Name: uart_reg_bridge

Overview:
Parametrised UART command-protocol engine that turns received byte frames into register read/write accesses and returns a response frame. It sits between the UART RX/TX byte cores and the IFC register access port. Frame lengths, address width and data width are generic. It adds checksum checking, inter-byte timeout, register ack timeout and error responses.

Parameters:
ADDR_BYTES, 2, number of address bytes per frame (1..4), sent MSB first
DATA_BYTES, 4, number of data bytes per access (1..4), sent MSB first
BYTE_TIMEOUT, 100000, maximum sys_clk cycles allowed between consecutive frame bytes
ACK_TIMEOUT, 255, maximum sys_clk cycles reg_req may wait for reg_ack

Ports:
sys_clk  in  1  system clock
rst_n  in  1  reset: asynchronous, active-low
rx_valid  in  1  single-cycle strobe: rx_data holds a received byte
rx_data  in  8  received byte
tx_data  out  8  byte to transmit
tx_valid  out  1  tx_data valid; held until tx_ready
tx_ready  in  1  TX core accepts tx_data this cycle
reg_req  out  1  register access request
reg_we  out  1  1 = write, 0 = read; valid while reg_req
reg_addr  out  ADDR_BYTES*8  access address
reg_wdata  out  DATA_BYTES*8  write data
reg_rdata  in  DATA_BYTES*8  read data; sampled in the reg_ack cycle
reg_ack  in  1  access complete, single cycle
busy  out  1  high in every state except IDLE
rx_overrun  out  1  one-cycle pulse: a byte arrived in ACCESS or RESP and was dropped
err_cnt  out  8  saturating count of rejected or timed-out frames

Behaviour:
- Reset: every output 0, FSM IDLE, counters cleared. Asserting reset mid-frame or mid-access aborts it. No response is sent and reg_req drops immediately.
- Request frame: 0xA5, CMD, ADDR bytes, DATA bytes (write only), CSUM.
  - CMD 0x57 = write, 0x52 = read.
  - CSUM = 8-bit sum mod 256 of CMD, ADDR and DATA bytes.
- Response frame: 0x5A, then one of:
  - write OK: 0x57
  - read OK: 0x52, DATA bytes
  - error: 0x45, CODE
  - followed by CSUM = sum mod 256 of all response bytes after 0x5A.
- Error codes: 0x01 bad checksum, 0x02 unknown command, 0x03 register ack timeout.
- FSM states:
  - IDLE: bytes other than 0xA5 are ignored. 0xA5 goes to CMD.
  - CMD: 0x52 or 0x57 goes to ADDR. Any other byte: increment err_cnt, go to RESP with code 0x02.
  - ADDR: shift in ADDR_BYTES bytes. Then go to DATA for a write, CSUM for a read.
  - DATA: shift in DATA_BYTES bytes, then go to CSUM.
  - CSUM: on match go to ACCESS. On mismatch increment err_cnt and go to RESP with code 0x01; no register access occurs.
  - ACCESS: reg_req rises the cycle after the CSUM byte. reg_we, reg_addr and reg_wdata are stable while reg_req is high. On reg_ack, reg_req falls the next cycle, read data is latched, and the FSM goes to RESP. If ACK_TIMEOUT cycles pass without reg_ack, reg_req falls, err_cnt increments, and the FSM goes to RESP with code 0x03.
  - RESP: bytes are presented in order. Each byte is held with tx_valid=1 until tx_ready. The next byte is presented the following cycle. After the last byte, tx_valid=0 and the FSM returns to IDLE.
- Inter-byte timeout:
  - Applies in CMD, ADDR, DATA and CSUM.
  - A counter resets on every accepted byte. On reaching BYTE_TIMEOUT, err_cnt increments and the FSM returns to IDLE silently.
  - If rx_valid coincides with expiry, the byte wins and the counter resets.
- rx_valid in ACCESS or RESP: the byte is dropped and rx_overrun pulses.
- err_cnt saturates at 0xFF.
- reg_ack outside ACCESS is ignored.

Test Plan:
Bench defaults: ADDR_BYTES=2, DATA_BYTES=4, ACK_TIMEOUT=255; tx_ready tied high unless stated.
- Write: send A5 57 00 10 DE AD BE EF 9F -> one reg_req with reg_we=1, reg_addr=0x0010, reg_wdata=0xDEADBEEF. After ack, TX bytes 5A 57 57.
- Read: send A5 52 00 20 72; ack with reg_rdata=0x12345678 -> reg_we=0, reg_addr=0x0020. TX bytes 5A 52 12 34 56 78 66.
- Bad checksum: send A5 52 00 20 00 -> no reg_req. TX bytes 5A 45 01 46; err_cnt=1.
- Unknown command: send A5 41 -> TX bytes 5A 45 02 47 immediately. Then a valid read frame completes normally.
- Ack timeout: valid read frame, reg_ack held 0 -> reg_req drops after 255 cycles. TX bytes 5A 45 03 48; err_cnt increments.
- Robustness, inter-byte timeout: send A5 57 00, stall BYTE_TIMEOUT cycles -> busy falls, no TX, err_cnt increments.
- Robustness, backpressure: tx_ready toggling 1-in-3 cycles -> bytes held stable, none lost.
- Robustness, overrun: rx_valid during ACCESS -> rx_overrun pulses for one cycle.
- Robustness, reset: rst_n pulsed mid-RESP -> all outputs 0.

Source files
------------

// File: rtl/uart_reg_bridge_if.sv
// -----------------------------------------------------------------------------
// uart_reg_bridge_if
// Bundles the byte-stream and register-access signals of uart_reg_bridge.
//
//   rx_valid / rx_data         : received byte strobe from the UART RX core
//   tx_data / tx_valid / tx_ready : byte handshake towards the UART TX core
//   reg_req / reg_we / reg_addr / reg_wdata / reg_rdata / reg_ack
//                              : register access port (IFC side)
//
// Modports:
//   master : the bridge (consumes RX bytes, drives TX and register requests)
//   slave  : the surrounding UART cores and register file
// -----------------------------------------------------------------------------
interface uart_reg_bridge_if #(
  parameter int ADDR_BYTES = 2,
  parameter int DATA_BYTES = 4
);
  logic                    rx_valid;
  logic [7:0]              rx_data;
  logic [7:0]              tx_data;
  logic                    tx_valid;
  logic                    tx_ready;
  logic                    reg_req;
  logic                    reg_we;
  logic [ADDR_BYTES*8-1:0] reg_addr;
  logic [DATA_BYTES*8-1:0] reg_wdata;
  logic [DATA_BYTES*8-1:0] reg_rdata;
  logic                    reg_ack;

  modport master (
    input  rx_valid, rx_data, tx_ready, reg_rdata, reg_ack,
    output tx_data, tx_valid, reg_req, reg_we, reg_addr, reg_wdata
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, reg_rdata, reg_ack,
    input  tx_data, tx_valid, reg_req, reg_we, reg_addr, reg_wdata
  );
endinterface

// File: rtl/uart_reg_bridge.sv
// -----------------------------------------------------------------------------
// uart_reg_bridge
// UART command-protocol engine: parses request frames from the RX byte stream,
// performs one register read or write, and streams back a response frame.
//
// Request : A5, CMD (57 write / 52 read), ADDR bytes, DATA bytes (write), CSUM
// Response: 5A, 57 | 52 DATA.. | 45 CODE, CSUM   (CSUM = sum of bytes after 5A)
// Error codes: 01 bad checksum, 02 unknown command, 03 register ack timeout.
//
// Ports:
//   sys_clk    : system clock
//   rst_n      : asynchronous active-low reset; aborts any frame or access
//   bus        : uart_reg_bridge_if.master (RX/TX bytes and register port)
//   busy       : high whenever the FSM is not IDLE
//   rx_overrun : one-cycle pulse, a byte arrived during ACCESS/RESP and was lost
//   err_cnt    : saturating count of rejected or timed-out frames
// -----------------------------------------------------------------------------
module uart_reg_bridge #(
  parameter int ADDR_BYTES   = 2,
  parameter int DATA_BYTES   = 4,
  parameter int BYTE_TIMEOUT = 100000,
  parameter int ACK_TIMEOUT  = 255
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  uart_reg_bridge_if.master        bus,
  output logic                     busy,
  output logic                     rx_overrun,
  output logic [7:0]               err_cnt
);

  localparam int ADDR_W = ADDR_BYTES * 8;
  localparam int DATA_W = DATA_BYTES * 8;
  localparam int TMO_W  = $clog2(BYTE_TIMEOUT + 1);
  localparam int ACK_W  = $clog2(ACK_TIMEOUT + 1);

  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(BYTE_TIMEOUT - 1);
  localparam logic [ACK_W-1:0] ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [1:0]       ADDR_LAST = 2'(ADDR_BYTES - 1);
  localparam logic [1:0]       DATA_LAST = 2'(DATA_BYTES - 1);

  localparam logic [7:0] SOF_REQ  = 8'hA5;
  localparam logic [7:0] SOF_RSP  = 8'h5A;
  localparam logic [7:0] CMD_WR   = 8'h57;
  localparam logic [7:0] CMD_RD   = 8'h52;
  localparam logic [7:0] RSP_ERR  = 8'h45;
  localparam logic [7:0] ERR_CSUM = 8'h01;
  localparam logic [7:0] ERR_CMD  = 8'h02;
  localparam logic [7:0] ERR_ACK  = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_CSUM, S_ACCESS, S_RESP
  } state_t;

  state_t            state_q,      state_d;
  logic              is_write_q,   is_write_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [DATA_W-1:0] wdata_q,      wdata_d;
  logic [DATA_W-1:0] rdata_q,      rdata_d;
  logic [7:0]        csum_q,       csum_d;
  logic [1:0]        byte_cnt_q,   byte_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q,    tmo_cnt_d;
  logic [ACK_W-1:0]  ack_cnt_q,    ack_cnt_d;
  logic [7:0]        err_code_q,   err_code_d;   // 0 = no error response
  logic [3:0]        tx_idx_q,     tx_idx_d;
  logic [7:0]        err_cnt_q,    err_cnt_d;
  logic              rx_overrun_q, rx_overrun_d;

  logic       err_inc;
  logic [7:0] resp_byte;
  logic [3:0] resp_last;
  logic [7:0] rd_sum;

  // ---------------------------------------------------------------------------
  // Response byte generator: byte tx_idx_q of the frame selected by the stored
  // error code / command type. Built from registers only, so tx_data cannot
  // change while a byte is held waiting for tx_ready.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned -- otherwise synthesis infers a latch.
    resp_byte = SOF_RSP;
    resp_last = 4'd0;
    rd_sum    = CMD_RD;
    for (int i = 0; i < DATA_BYTES; i++) begin
      rd_sum = rd_sum + rdata_q[i*8 +: 8];
    end

    if (err_code_q != 8'h00) begin
      resp_last = 4'd3;
      case (tx_idx_q)
        4'd0:    resp_byte = SOF_RSP;
        4'd1:    resp_byte = RSP_ERR;
        4'd2:    resp_byte = err_code_q;
        default: resp_byte = RSP_ERR + err_code_q;
      endcase
    end else if (is_write_q) begin
      resp_last = 4'd2;
      resp_byte = (tx_idx_q == 4'd0) ? SOF_RSP : CMD_WR;   // CMD and CSUM coincide
    end else begin
      resp_last = 4'(DATA_BYTES + 2);
      if (tx_idx_q == 4'd0) begin
        resp_byte = SOF_RSP;
      end else if (tx_idx_q == 4'd1) begin
        resp_byte = CMD_RD;
      end else if (tx_idx_q == resp_last) begin
        resp_byte = rd_sum;
      end else begin
        for (int i = 0; i < DATA_BYTES; i++) begin
          if (tx_idx_q == 4'(i + 2)) resp_byte = rdata_q[(DATA_BYTES-1-i)*8 +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    is_write_d   = is_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    csum_d       = csum_q;
    byte_cnt_d   = byte_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    ack_cnt_d    = ack_cnt_q;
    err_code_d   = err_code_q;
    tx_idx_d     = tx_idx_q;
    rx_overrun_d = 1'b0;
    err_inc      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid && bus.rx_data == SOF_REQ) begin
          state_d    = S_CMD;
          csum_d     = 8'h00;
          tmo_cnt_d  = '0;
          byte_cnt_d = 2'd0;
          err_code_d = 8'h00;
        end
      end

      S_CMD, S_ADDR, S_DATA, S_CSUM: begin
        if (!bus.rx_valid) begin
          // Silent abort: a stalled sender gets no response.
          if (tmo_cnt_q == TMO_LAST) begin
            err_inc = 1'b1;
            state_d = S_IDLE;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          end
        end else begin
          // A byte arriving on the expiry cycle still counts.
          tmo_cnt_d = '0;
          case (state_q)
            S_CMD: begin
              if (bus.rx_data == CMD_WR || bus.rx_data == CMD_RD) begin
                is_write_d = (bus.rx_data == CMD_WR);
                csum_d     = bus.rx_data;
                byte_cnt_d = 2'd0;
                state_d    = S_ADDR;
              end else begin
                err_inc    = 1'b1;
                err_code_d = ERR_CMD;
                tx_idx_d   = 4'd0;
                state_d    = S_RESP;
              end
            end
            S_ADDR: begin
              addr_d = (addr_q << 8) | ADDR_W'(bus.rx_data);
              csum_d = csum_q + bus.rx_data;
              if (byte_cnt_q == ADDR_LAST) begin
                byte_cnt_d = 2'd0;
                state_d    = is_write_q ? S_DATA : S_CSUM;
              end else begin
                byte_cnt_d = byte_cnt_q + 2'd1;
              end
            end
            S_DATA: begin
              wdata_d = (wdata_q << 8) | DATA_W'(bus.rx_data);
              csum_d  = csum_q + bus.rx_data;
              if (byte_cnt_q == DATA_LAST) begin
                state_d = S_CSUM;
              end else begin
                byte_cnt_d = byte_cnt_q + 2'd1;
              end
            end
            default: begin  // S_CSUM
              if (bus.rx_data == csum_q) begin
                ack_cnt_d = '0;
                state_d   = S_ACCESS;
              end else begin
                err_inc    = 1'b1;
                err_code_d = ERR_CSUM;
                tx_idx_d   = 4'd0;
                state_d    = S_RESP;
              end
            end
          endcase
        end
      end

      S_ACCESS: begin
        rx_overrun_d = bus.rx_valid;
        if (bus.reg_ack) begin
          if (!is_write_q) rdata_d = bus.reg_rdata;
          tx_idx_d = 4'd0;
          state_d  = S_RESP;
        end else if (ack_cnt_q == ACK_LAST) begin
          err_inc    = 1'b1;
          err_code_d = ERR_ACK;
          tx_idx_d   = 4'd0;
          state_d    = S_RESP;
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
      end

      S_RESP: begin
        rx_overrun_d = bus.rx_valid;
        if (bus.tx_ready) begin
          if (tx_idx_q == resp_last) begin
            state_d = S_IDLE;
          end else begin
            tx_idx_d = tx_idx_q + 4'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    err_cnt_d = err_cnt_q;
    if (err_inc && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: the address/data registers are reset as well, because they drive
  // reg_addr/reg_wdata directly and every output must read 0 out of reset.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      is_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      csum_q       <= 8'h00;
      byte_cnt_q   <= 2'd0;
      tmo_cnt_q    <= '0;
      ack_cnt_q    <= '0;
      err_code_q   <= 8'h00;
      tx_idx_q     <= 4'd0;
      err_cnt_q    <= 8'h00;
      rx_overrun_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      is_write_q   <= is_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      csum_q       <= csum_d;
      byte_cnt_q   <= byte_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      ack_cnt_q    <= ack_cnt_d;
      err_code_q   <= err_code_d;
      tx_idx_q     <= tx_idx_d;
      err_cnt_q    <= err_cnt_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all derived from registers)
  // ---------------------------------------------------------------------------
  assign bus.tx_valid  = (state_q == S_RESP);
  assign bus.tx_data   = (state_q == S_RESP) ? resp_byte : 8'h00;
  assign bus.reg_req   = (state_q == S_ACCESS);
  assign bus.reg_we    = is_write_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign busy          = (state_q != S_IDLE);
  assign rx_overrun    = rx_overrun_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// -----------------------------------------------------------------------------
// tb_uart_reg_bridge
// Directed bench for uart_reg_bridge: write, read, bad checksum, unknown
// command, ack timeout, inter-byte timeout (incl. byte-at-expiry), TX
// backpressure, RX overrun, reset mid-response / mid-access, err_cnt
// saturation. Inputs change on the falling edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_uart_reg_bridge;

  localparam int BT = 200;   // shortened inter-byte timeout for simulation

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       busy;
  logic       rx_overrun;
  logic [7:0] err_cnt;

  uart_reg_bridge_if #(.ADDR_BYTES(2), .DATA_BYTES(4)) u_if ();

  uart_reg_bridge #(
    .ADDR_BYTES  (2),
    .DATA_BYTES  (4),
    .BYTE_TIMEOUT(BT),
    .ACK_TIMEOUT (255)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .bus       (u_if),
    .busy      (busy),
    .rx_overrun(rx_overrun),
    .err_cnt   (err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // tx_ready pattern: 0 = always ready, 1 = ready one cycle in three, 2 = stalled
  int   ready_mode = 0;
  int   cyc        = 0;
  logic ready_q    = 1'b1;
  assign u_if.tx_ready = ready_q;

  always @(negedge sys_clk) begin
    cyc++;
    case (ready_mode)
      1:       ready_q = (cyc % 3 == 0);
      2:       ready_q = 1'b0;
      default: ready_q = 1'b1;
    endcase
  end

  // Monitor: accepted TX bytes, hold violations, reg_req activity, overruns.
  logic [7:0] tx_q[$];
  int         stall_viol = 0;
  int         req_cycles = 0;
  int         req_count  = 0;
  int         ovr_cycles = 0;
  logic       hold_pend  = 1'b0;
  logic [7:0] held       = 8'h00;
  logic       req_prev   = 1'b0;

  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
      req_prev  = 1'b0;
    end else begin
      if (u_if.tx_valid && u_if.tx_ready) tx_q.push_back(u_if.tx_data);
      if (hold_pend && (u_if.tx_valid !== 1'b1 || u_if.tx_data !== held)) stall_viol++;
      hold_pend = u_if.tx_valid && !u_if.tx_ready;
      held      = u_if.tx_data;
      if (u_if.reg_req) begin
        req_cycles++;
        if (!req_prev) req_count++;
      end
      req_prev = u_if.reg_req;
      if (rx_overrun) ovr_cycles++;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send(input logic [7:0] b);
    u_if.rx_valid = 1'b1;
    u_if.rx_data  = b;
    @(negedge sys_clk);
    u_if.rx_valid = 1'b0;
    u_if.rx_data  = 8'h00;
  endtask

  task automatic ack(input logic [31:0] rdata);
    u_if.reg_rdata = rdata;
    u_if.reg_ack   = 1'b1;
    @(negedge sys_clk);
    u_if.reg_ack   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    check(tag, busy, 64'h0);
  endtask

  // n expected bytes packed MSB-first into the low bytes of exp.
  task automatic check_resp(input string tag, input int n, input logic [63:0] exp);
    logic [63:0] obs = '0;
    check({tag, "_len"}, tx_q.size(), n);
    foreach (tx_q[i]) obs = (obs << 8) | 64'(tx_q[i]);
    check({tag, "_bytes"}, obs, exp);
  endtask

  task automatic clear_mon();
    tx_q.delete();
    stall_viol = 0;
    req_cycles = 0;
    req_count  = 0;
    ovr_cycles = 0;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.rx_valid  = 1'b0;
    u_if.rx_data   = 8'h00;
    u_if.reg_ack   = 1'b0;
    u_if.reg_rdata = 32'h0;
    tick(3);

    // ---- reset state
    check("rst_busy",    busy,           0);
    check("rst_tx_valid", u_if.tx_valid, 0);
    check("rst_tx_data", u_if.tx_data,   0);
    check("rst_reg_req", u_if.reg_req,   0);
    check("rst_reg_we",  u_if.reg_we,    0);
    check("rst_addr",    u_if.reg_addr,  0);
    check("rst_wdata",   u_if.reg_wdata, 0);
    check("rst_err_cnt", err_cnt,        0);
    check("rst_overrun", rx_overrun,     0);
    rst_n = 1'b1;
    tick(2);

    // ---- write
    clear_mon();
    send(8'hA5); send(8'h57); send(8'h00); send(8'h10);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF); send(8'h9F);
    check("wr_req_rise", u_if.reg_req,   1);
    check("wr_we",       u_if.reg_we,    1);
    check("wr_addr",     u_if.reg_addr,  64'h0010);
    check("wr_wdata",    u_if.reg_wdata, 64'hDEADBEEF);
    tick(2);
    check("wr_req_held", u_if.reg_req,   1);
    ack(32'h0);
    check("wr_req_fall", u_if.reg_req,   0);
    wait_idle("wr_idle", 50);
    check_resp("wr_resp", 3, 64'h5A5757);
    check("wr_req_count", req_count, 1);

    // ---- read, with a byte arriving during ACCESS
    clear_mon();
    send(8'hA5); send(8'h52); send(8'h00); send(8'h20); send(8'h72);
    check("rd_req",  u_if.reg_req,  1);
    check("rd_we",   u_if.reg_we,   0);
    check("rd_addr", u_if.reg_addr, 64'h0020);
    send(8'h33);
    check("ovr_pulse", rx_overrun, 1);
    tick(1);
    check("ovr_clear", rx_overrun, 0);
    ack(32'h12345678);
    wait_idle("rd_idle", 50);
    check_resp("rd_resp", 7, 64'h5A521234567866);
    check("ovr_cycles", ovr_cycles, 1);
    check("rd_err_cnt", err_cnt, 0);

    // ---- bad checksum
    clear_mon();
    send(8'hA5); send(8'h52); send(8'h00); send(8'h20); send(8'h00);
    wait_idle("csum_idle", 50);
    check("csum_no_req", req_count, 0);
    check_resp("csum_resp", 4, 64'h5A450146);
    check("csum_err_cnt", err_cnt, 1);

    // ---- unknown command, then a normal read
    clear_mon();
    send(8'hA5); send(8'h41);
    check("cmd_tx_valid", u_if.tx_valid, 1);
    check("cmd_tx_sof",   u_if.tx_data,  64'h5A);
    wait_idle("cmd_idle", 50);
    check_resp("cmd_resp", 4, 64'h5A450247);
    check("cmd_err_cnt", err_cnt, 2);
    clear_mon();
    send(8'hA5); send(8'h52); send(8'h00); send(8'h20); send(8'h72);
    check("cmd_rd_req", u_if.reg_req, 1);
    ack(32'hCAFEF00D);
    wait_idle("cmd_rd_idle", 50);
    check_resp("cmd_rd_resp", 7, 64'h5A52CAFEF00D17);

    // ---- reg_ack outside ACCESS is ignored
    clear_mon();
    ack(32'hFFFFFFFF);
    tick(3);
    check("stray_ack_busy", busy, 0);
    check("stray_ack_tx",   tx_q.size(), 0);

    // ---- register ack timeout
    clear_mon();
    send(8'hA5); send(8'h52); send(8'h00); send(8'h20); send(8'h72);
    wait_idle("ackto_idle", 400);
    check("ackto_req_cycles", req_cycles, 255);
    check("ackto_req_count",  req_count,  1);
    check_resp("ackto_resp", 4, 64'h5A450348);
    check("ackto_err_cnt", err_cnt, 3);

    // ---- inter-byte timeout: silent return to IDLE
    clear_mon();
    send(8'hA5); send(8'h57); send(8'h00);
    tick(BT - 1);
    check("bto_busy_before", busy, 1);
    tick(1);
    check("bto_busy_after", busy, 0);
    tick(5);
    check("bto_no_tx",   tx_q.size(), 0);
    check("bto_no_req",  req_count,   0);
    check("bto_err_cnt", err_cnt,     4);

    // ---- byte arriving on the expiry cycle wins
    clear_mon();
    send(8'hA5); send(8'h52); send(8'h00);
    tick(BT - 1);
    send(8'h20);
    tick(BT - 1);
    send(8'h72);
    check("bwin_req", u_if.reg_req, 1);
    ack(32'h00000001);
    wait_idle("bwin_idle", 50);
    check_resp("bwin_resp", 7, 64'h5A52000000015 << 4 | 64'h3);
    check("bwin_err_cnt", err_cnt, 4);

    // ---- TX backpressure
    clear_mon();
    ready_mode = 1;
    send(8'hA5); send(8'h52); send(8'h00); send(8'h20); send(8'h72);
    ack(32'h12345678);
    wait_idle("bp_idle", 100);
    check_resp("bp_resp", 7, 64'h5A521234567866);
    check("bp_hold_viol", stall_viol, 0);
    ready_mode = 0;

    // ---- reset mid-RESP
    clear_mon();
    ready_mode = 2;
    send(8'hA5); send(8'h41);
    tick(2);
    check("rresp_tx_valid", u_if.tx_valid, 1);
    check("rresp_tx_data",  u_if.tx_data,  64'h5A);
    check("rresp_err_cnt",  err_cnt,       5);
    rst_n = 1'b0;
    #1;
    check("rresp_rst_tx_valid", u_if.tx_valid, 0);
    check("rresp_rst_tx_data",  u_if.tx_data,  0);
    check("rresp_rst_busy",     busy,          0);
    check("rresp_rst_err_cnt",  err_cnt,       0);
    check("rresp_rst_reg_req",  u_if.reg_req,  0);
    @(negedge sys_clk);
    rst_n      = 1'b1;
    ready_mode = 0;
    tick(4);
    check("rresp_post_busy", busy, 0);
    check("rresp_post_tx",   tx_q.size(), 0);

    // ---- reset mid-ACCESS drops reg_req at once
    clear_mon();
    send(8'hA5); send(8'h52); send(8'h00); send(8'h20); send(8'h72);
    check("racc_req", u_if.reg_req, 1);
    rst_n = 1'b0;
    #1;
    check("racc_rst_req",  u_if.reg_req,  0);
    check("racc_rst_addr", u_if.reg_addr, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    tick(4);
    check("racc_post_tx", tx_q.size(), 0);

    // ---- err_cnt saturation
    for (int i = 0; i < 254; i++) begin
      send(8'hA5); send(8'h41);
      tick(6);
    end
    check("sat_254", err_cnt, 8'hFE);
    send(8'hA5); send(8'h41);
    tick(6);
    check("sat_255", err_cnt, 8'hFF);
    send(8'hA5); send(8'h41);
    tick(6);
    check("sat_hold", err_cnt, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
